// File: rtl/priority_decoder.sv
// priority_decoder
//   Sequential counterpart to the 4-input priority encoder. Encoded request
//   indices are buffered in a small FIFO and replayed one at a time as a
//   one-hot grant on `out`. Each grant is held for HOLD cycles and is always
//   followed by one all-zero cycle, so two grants never overlap.
//
// Parameters
//   IDX_W : index width; the grant bus has N = 2**IDX_W lines
//   HOLD  : cycles each grant stays asserted (1..255)
//   DEPTH : request FIFO entries (power of two, >= 2)
//
// Ports
//   clk      : clock, all state updates on the rising edge
//   rst_n    : asynchronous active-low reset
//   in       : encoded request index
//   valid    : `in` is meaningful this cycle
//   in_ready : FIFO not full (does not account for a same-cycle pop)
//   out      : one-hot grant, all zero when not granting
//   done     : high during the last cycle of each grant
//   busy     : FSM not idle, or requests still queued
//   ovf      : sticky, at least one request was dropped
//   drop_cnt : saturating count of dropped requests
//              (present only when PRIORITY_DECODER_DROPCNT_EN is defined)
//
// Build option
//   PRIORITY_DECODER_DROPCNT_EN : adds the drop_cnt port and counter.

module priority_decoder #(
  parameter int IDX_W = 2,
  parameter int HOLD  = 3,
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [IDX_W-1:0]      in,
  input  logic                  valid,
  output logic                  in_ready,
  output logic [2**IDX_W-1:0]   out,
  output logic                  done,
  output logic                  busy,
  output logic                  ovf
`ifdef PRIORITY_DECODER_DROPCNT_EN
  ,
  output logic [7:0]            drop_cnt
`endif
);

  localparam int N  = 2 ** IDX_W;
  localparam int AW = $clog2(DEPTH);
  localparam logic [7:0] HOLD_M1 = 8'(HOLD - 1);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    GAP
  } state_t;

  state_t            state, next_state;
  logic [7:0]        cnt, next_cnt;
  logic [IDX_W-1:0]  grant_idx, next_grant;

  logic [IDX_W-1:0]  mem [DEPTH];
  logic [AW:0]       wr_ptr, rd_ptr;
  logic              full, empty;
  logic              push, pop, drop;

  // Pointers carry one extra wrap bit: equal pointers mean empty, equal
  // addresses with differing wrap bits mean full.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // Fullness is judged before any same-edge pop, so a push into a full FIFO
  // is dropped even when the FSM frees a slot on that edge.
  assign push = valid && !full;
  assign drop = valid && full;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (drop) ovf    <= 1'b1;
    end
  end

`ifdef PRIORITY_DECODER_DROPCNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= 8'd0;
    end else if (drop && (drop_cnt != 8'hFF)) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 8'd0;
      grant_idx <= '0;
    end else begin
      state     <= next_state;
      cnt       <= next_cnt;
      grant_idx <= next_grant;
    end
  end

  // Outputs are decoded purely from registered state, so `out` and `done`
  // drop to zero the moment reset is asserted.
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    next_grant = grant_idx;
    pop        = 1'b0;
    out        = '0;
    done       = 1'b0;

    case (state)
      IDLE, GAP: begin
        if (!empty) begin
          pop        = 1'b1;
          next_grant = mem[rd_ptr[AW-1:0]];
          next_cnt   = HOLD_M1;
          next_state = GRANT;
        end else begin
          next_state = IDLE;
        end
      end
      GRANT: begin
        out = N'(1) << grant_idx;
        if (cnt == 8'd0) begin
          done       = 1'b1;
          next_state = GAP;
        end else begin
          next_cnt = cnt - 8'd1;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  assign in_ready = !full;
  assign busy     = (state != IDLE) || !empty;

endmodule

// File: tb/tb_priority_decoder.sv
// tb_priority_decoder
//   Directed bench for priority_decoder with IDX_W=2, HOLD=3, DEPTH=4.
//   Each scenario task drives its own stimulus and checks against
//   hand-computed expectations. Inputs change and outputs are sampled 1ns
//   after the rising edge.

module tb_priority_decoder;

  logic       clk;
  logic       rst_n;
  logic [1:0] din;
  logic       valid;
  logic       in_ready;
  logic [3:0] out;
  logic       done;
  logic       busy;
  logic       ovf;
`ifdef PRIORITY_DECODER_DROPCNT_EN
  logic [7:0] drop_cnt;
`endif

  int total;
  int bad;

  priority_decoder #(
    .IDX_W(2),
    .HOLD (3),
    .DEPTH(4)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in      (din),
    .valid   (valid),
    .in_ready(in_ready),
    .out     (out),
    .done    (done),
    .busy    (busy),
    .ovf     (ovf)
`ifdef PRIORITY_DECODER_DROPCNT_EN
    ,
    .drop_cnt(drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past one rising edge and settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    valid = 1'b0;
    din   = 2'b00;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (out !== 4'b0000) begin bad++; $display("[TB] FAIL reset_out got=%b want=0000", out); end
    total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL reset_done got=%b want=0", done); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b want=0", busy); end
    total++; if (ovf !== 1'b0) begin bad++; $display("[TB] FAIL reset_ovf got=%b want=0", ovf); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_in_ready got=%b want=1", in_ready); end
`ifdef PRIORITY_DECODER_DROPCNT_EN
    total++; if (drop_cnt !== 8'd0) begin bad++; $display("[TB] FAIL reset_drop_cnt got=%0d want=0", drop_cnt); end
`endif
    tick();
    tick();
    total++; if (out !== 4'b0000 || busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_held got out=%b busy=%b want 0000/0", out, busy); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    do_reset();
    valid = 1'b1;
    din   = 2'b10;
    tick();
    valid = 1'b0;
    total++; if (out !== 4'b0000) begin bad++; $display("[TB] FAIL single_pre_out got=%b want=0000", out); end
    total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL single_busy_rise got=%b want=1", busy); end
    for (int c = 1; c <= 3; c++) begin
      tick();
      total++; if (out !== 4'b0100) begin bad++; $display("[TB] FAIL single_out_c%0d got=%b want=0100", c, out); end
      total++; if (done !== (c == 3)) begin bad++; $display("[TB] FAIL single_done_c%0d got=%b want=%b", c, done, (c == 3)); end
    end
    tick();
    total++; if (out !== 4'b0000 || done !== 1'b0) begin bad++; $display("[TB] FAIL single_gap got out=%b done=%b want 0000/0", out, done); end
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL single_busy_fall got=%b want=0", busy); end
  endtask

  task automatic test_burst();
    logic [3:0] exp_seq [12];
    logic [3:0] obs [12];
    int         multi;
    exp_seq = '{4'b0001, 4'b0001, 4'b0001, 4'b0000,
                4'b0010, 4'b0010, 4'b0010, 4'b0000,
                4'b1000, 4'b1000, 4'b1000, 4'b0000};
    multi = 0;
    do_reset();
    valid = 1'b1;
    din   = 2'b00;
    tick();
    total++; if (out !== 4'b0000) begin bad++; $display("[TB] FAIL burst_pre_out got=%b want=0000", out); end
    din = 2'b01;
    tick();
    obs[0] = out;
    din = 2'b11;
    tick();
    obs[1] = out;
    valid = 1'b0;
    for (int i = 2; i < 12; i++) begin
      tick();
      obs[i] = out;
    end
    for (int i = 0; i < 12; i++) begin
      if ($countones(obs[i]) > 1) multi++;
      total++; if (obs[i] !== exp_seq[i]) begin bad++; $display("[TB] FAIL burst_out_%0d got=%b want=%b", i, obs[i], exp_seq[i]); end
    end
    total++; if (multi !== 0) begin bad++; $display("[TB] FAIL burst_onehot got=%0d want=0", multi); end
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL burst_busy_end got=%b want=0", busy); end
  endtask

  task automatic test_overflow();
    logic [1:0] pat [6];
    logic [3:0] exp_g [5];
    logic [3:0] grants [$];
    logic [3:0] prev;
    int         dones;
    pat   = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    prev  = 4'b0000;
    dones = 0;
    do_reset();
    for (int e = 0; e < 40; e++) begin
      valid = (e < 6);
      din   = (e < 6) ? pat[e] : 2'b00;
      tick();
      if (e == 3) begin
        total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL ovf_ready_e3 got=%b want=1", in_ready); end
      end
      if (e == 4) begin
        total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL ovf_ready_full got=%b want=0", in_ready); end
        total++; if (ovf !== 1'b0) begin bad++; $display("[TB] FAIL ovf_early got=%b want=0", ovf); end
      end
      if (e == 5) begin
        total++; if (ovf !== 1'b1) begin bad++; $display("[TB] FAIL ovf_set got=%b want=1", ovf); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL ovf_ready_e5 got=%b want=1", in_ready); end
      end
      if (out !== 4'b0000 && prev === 4'b0000) grants.push_back(out);
      if (done === 1'b1) dones++;
      prev = out;
    end
    valid = 1'b0;
    total++; if (grants.size() !== 5) begin bad++; $display("[TB] FAIL ovf_grant_count got=%0d want=5", grants.size()); end
    for (int i = 0; i < 5; i++) begin
      if (i < grants.size()) begin
        total++; if (grants[i] !== exp_g[i]) begin bad++; $display("[TB] FAIL ovf_grant_%0d got=%b want=%b", i, grants[i], exp_g[i]); end
      end
    end
    total++; if (dones !== 5) begin bad++; $display("[TB] FAIL ovf_done_count got=%0d want=5", dones); end
    total++; if (ovf !== 1'b1 || busy !== 1'b0) begin bad++; $display("[TB] FAIL ovf_end got ovf=%b busy=%b want 1/0", ovf, busy); end
`ifdef PRIORITY_DECODER_DROPCNT_EN
    total++; if (drop_cnt !== 8'd1) begin bad++; $display("[TB] FAIL ovf_drop_cnt got=%0d want=1", drop_cnt); end
`endif
  endtask

  task automatic test_reset_mid_grant();
    int nonzero;
    int busy_hi;
    nonzero = 0;
    busy_hi = 0;
    do_reset();
    valid = 1'b1;
    din   = 2'b11;
    tick();
    din = 2'b00;
    tick();
    din = 2'b01;
    tick();
    valid = 1'b0;
    total++; if (out !== 4'b1000) begin bad++; $display("[TB] FAIL midrst_pre_out got=%b want=1000", out); end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (out !== 4'b0000) begin bad++; $display("[TB] FAIL midrst_out got=%b want=0000", out); end
    total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("[TB] FAIL midrst_busy_done got busy=%b done=%b want 0/0", busy, done); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL midrst_in_ready got=%b want=1", in_ready); end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (out !== 4'b0000) nonzero++;
      if (busy !== 1'b0) busy_hi++;
    end
    total++; if (nonzero !== 0) begin bad++; $display("[TB] FAIL midrst_no_grants got=%0d want=0", nonzero); end
    total++; if (busy_hi !== 0) begin bad++; $display("[TB] FAIL midrst_busy_after got=%0d want=0", busy_hi); end
  endtask

  task automatic test_push_pop();
    logic [1:0] pat [7];
    logic       pv  [7];
    logic [3:0] exp_g [6];
    logic [3:0] grants [$];
    logic [3:0] prev;
    pat   = '{2'd2, 2'd1, 2'd3, 2'd0, 2'd0, 2'd1, 2'd2};
    pv    = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    exp_g = '{4'b0100, 4'b0010, 4'b1000, 4'b0001, 4'b0010, 4'b0100};
    prev  = 4'b0000;
    do_reset();
    for (int e = 0; e < 40; e++) begin
      valid = (e < 7) ? pv[e] : 1'b0;
      din   = (e < 7) ? pat[e] : 2'b00;
      tick();
      if (e == 4) begin
        total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL pp_ready_three got=%b want=1", in_ready); end
      end
      if (e == 5) begin
        total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL pp_ready_same got=%b want=1", in_ready); end
      end
      if (e == 6) begin
        total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL pp_ready_full got=%b want=0", in_ready); end
      end
      if (out !== 4'b0000 && prev === 4'b0000) grants.push_back(out);
      prev = out;
    end
    valid = 1'b0;
    total++; if (grants.size() !== 6) begin bad++; $display("[TB] FAIL pp_grant_count got=%0d want=6", grants.size()); end
    for (int i = 0; i < 6; i++) begin
      if (i < grants.size()) begin
        total++; if (grants[i] !== exp_g[i]) begin bad++; $display("[TB] FAIL pp_grant_%0d got=%b want=%b", i, grants[i], exp_g[i]); end
      end
    end
    total++; if (ovf !== 1'b0) begin bad++; $display("[TB] FAIL pp_ovf got=%b want=0", ovf); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b1;
    valid = 1'b0;
    din   = 2'b00;
    test_reset();
    test_single();
    test_burst();
    test_overflow();
    test_reset_mid_grant();
    test_push_pop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/priority_decoder.md
# priority_decoder

- Sequential counterpart to the 4-input priority encoder: accepts a binary index plus a valid flag, buffers the requests, and replays each as a one-hot grant on `out`.
- Each grant is held for a fixed number of cycles and is followed by one all-zero cycle, so consecutive grants never overlap (break-before-make).
- Sits downstream of the encoder and drives per-line service or acknowledge logic.

## Interface
- `IDX_W`, default 2: index width; N = 2**IDX_W output lines.
- `HOLD`, default 3: cycles each grant stays asserted; legal range 1..255.
- `DEPTH`, default 4: request FIFO entries; power of two, ≥2.
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `in`, input, IDX_W: encoded index from the encoder.
- `valid`, input, 1: `in` is meaningful this cycle; sampled every rising edge.
- `in_ready`, output, 1: FIFO not full.
- `out`, output, N: one-hot grant; all zero when not granting.
- `done`, output, 1: high during the last cycle of each grant.
- `busy`, output, 1: FSM not IDLE, or FIFO not empty.
- `ovf`, output, 1: sticky flag; at least one request was dropped.
- `drop_cnt`, output, 8: dropped-request count; present only with `PRIORITY_DECODER_DROPCNT_EN`.

## Operation
- **Push:** at each edge, if `valid` && !full, write `in` to the FIFO tail.
- **Drop:** if `valid` && full, discard the request and set `ovf`. `ovf` clears only on reset.
- **`in_ready`:** equals !full and ignores any same-cycle pop (conservative). A push into a full FIFO is dropped even if a pop occurs on the same edge.
- **Simultaneous push and pop** when not full: both occur; occupancy is unchanged.
- **FSM states:** IDLE, GRANT, GAP.
  - IDLE: if FIFO non-empty, pop the head into `grant_idx`, load `cnt = HOLD-1`, go to GRANT. Else stay.
  - GRANT: `out = 1 << grant_idx`.
    - If `cnt == 0`: assert `done`, go to GAP.
    - Else: `cnt` decrements.
  - GAP: `out = 0`.
    - If FIFO non-empty: pop, reload `cnt`, go to GRANT.
    - Else: go to IDLE.
- **Output rules:**
  - `out` is decoded from registered state only, never directly from `in`.
  - Exactly zero or one bit of `out` is set in every cycle.
- **Counter:** `cnt` is 8 bits. With HOLD=1, GRANT lasts one cycle and `done` is high in that cycle.
- **FIFO pointers:** log2(DEPTH)+1 bits each, wrapping modulo 2·DEPTH. full/empty come from the MSB comparison.
- **Reset, including mid-grant:** `out`, `done`, `busy`, `ovf` and `drop_cnt` go to 0 immediately. FIFO is emptied, FSM goes to IDLE, `in_ready` goes to 1. No grant in flight is resumed after reset.

## Timing
- **Latency:** with FIFO empty and FSM in IDLE, a request sampled at edge k gives the FIFO entry after edge k. It is popped at edge k+1, and `out` is asserted from edge k+1 through edge k+1+HOLD.
- **Throughput:** one grant every HOLD+1 cycles with back-to-back requests queued; the GAP cycle is the only dead cycle.
- **`done`:** coincides with the final `out`-asserted cycle and is registered.
- **`busy`:** rises the cycle after the first push. It falls in the cycle the FSM enters IDLE with the FIFO empty.
- **`in_ready`:** updates one cycle after the push or pop that changes fullness.

## Configuration
- **`PRIORITY_DECODER_DROPCNT_EN` defined:**
  - `drop_cnt` port exists.
  - It increments on every dropped request and saturates at 255.
  - Reset value is 0.
- **Not defined:**
  - Port and counter are absent.
  - `ovf` alone reports drops.
  - All other behaviour is identical.

## Test plan
All scenarios use IDX_W=2, HOLD=3, DEPTH=4.
- **Reset:** hold `rst_n`=0 → `out`=0000, `done`=0, `busy`=0, `ovf`=0, `in_ready`=1.
- **Single request:** `in`=10, `valid` for one cycle → `out`=0100 for exactly 3 cycles starting 2 edges later. `done` is high on the 3rd cycle, then `out`=0000 and `busy`=0.
- **Burst:**
  - Stimulus: push 00, 01, 11 on consecutive cycles.
  - `out` sequence: 0001×3, 0000, 0010×3, 0000, 1000×3, 0000.
  - Never two bits set at once.
- **Overflow:**
  - Stimulus: 6 consecutive pushes while the first grant is active; 4 are held.
  - `in_ready`=0 when full, and `ovf`=1 after the first drop.
  - Exactly 5 grants follow (1 in flight plus 4 queued).
  - With the macro defined, `drop_cnt`=1.
- **Reset mid-grant:** assert `rst_n`=0 during the 2nd cycle of `out`=1000 with 2 queued → `out`=0000 asynchronously. After release, no grants appear and `busy`=0.
- **Simultaneous push and pop:** FIFO at 3 entries with a pop at edge k and a push at edge k → occupancy stays 3. Order is preserved, verified by the grant sequence.
